// File: rtl/ncr_dma_bridge.sv
// ncr_dma_bridge: arbitrates the NCR53C710 bus master and turns each NCR bus cycle into one DMA request,
// terminating it with TA_n on completion or TEA_n on timeout.
module ncr_dma_bridge #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET_n,
  input  logic             NCR_BR_n,
  output logic             NCR_BG_n,
  input  logic             NCR_BGACK_n,
  input  logic             NCR_AS_n,
  input  logic             NCR_RW,
  input  logic [1:0]       NCR_SIZ,
  input  logic [31:0]      NCR_ADDR,
  output logic             NCR_TA_n,
  output logic             NCR_TEA_n,
  output logic             START_DMA,
  output logic             READ,
  output logic [31:0]      ADDR,
  output logic [3:0]       BYTE_EN,
  input  logic             DTACK_ACK,
  input  logic             ACTIVE,
  input  logic             TIMEOUT_CLR,
  output logic [CNT_W-1:0] XFER_COUNT,
  output logic             TIMEOUT_ERR
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, GRANT, OWNED, ISSUE, WAIT_ACK, TERM, ERR, WAIT_NEG} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic [2:0] o, n;
  logic [3:0] be_d, be_q;
  logic [31:0] addr_q;
  logic read_q, start_q, bg_q, ta_q, tea_q, err_q;
  logic [CNT_W-1:0] cnt_q;
  wire tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = !NCR_BR_n ? GRANT : IDLE;
      GRANT:    state_d = !NCR_BGACK_n ? OWNED : NCR_BR_n ? IDLE : GRANT;
      OWNED:    state_d = !NCR_AS_n ? ISSUE : NCR_BGACK_n ? IDLE : OWNED;
      ISSUE:    state_d = !ACTIVE ? WAIT_ACK : ISSUE;
      WAIT_ACK: state_d = DTACK_ACK ? TERM : tmo_hit ? ERR : WAIT_ACK;
      TERM:     state_d = WAIT_NEG;
      ERR:      state_d = WAIT_NEG;
      WAIT_NEG: state_d = NCR_AS_n ? OWNED : WAIT_NEG;
      default:  state_d = IDLE;
    endcase
  end
  // lane k (k=0 is D31:24) is enabled for offset <= k < offset+size; the 4-lane limit is implicit
  always_comb begin
    o = {1'b0, NCR_ADDR[1:0]};
    n = (NCR_SIZ == 2'b00) ? 3'd4 : {1'b0, NCR_SIZ};
    be_d = '0;
    for (int k = 0; k < 4; k++) be_d[3-k] = (3'(k) >= o) && (3'(k) < o + n);
  end
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      bg_q    <= 1'b1;
      ta_q    <= 1'b1;
      tea_q   <= 1'b1;
      start_q <= 1'b0;
      read_q  <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= (state_q == WAIT_ACK) ? tmo_q + 1'b1 : '0;
      bg_q    <= state_d != GRANT;
      ta_q    <= state_d != TERM;
      tea_q   <= state_d != ERR;
      start_q <= state_q == ISSUE && !ACTIVE;
      if (state_q == OWNED && !NCR_AS_n) begin
        addr_q <= NCR_ADDR;
        read_q <= NCR_RW;
        be_q   <= be_d;
      end
      if (state_d == TERM) cnt_q <= cnt_q + 1'b1;
      err_q   <= (state_d == ERR) || (err_q && !TIMEOUT_CLR);
    end
  end
  assign NCR_BG_n    = bg_q;
  assign NCR_TA_n    = ta_q;
  assign NCR_TEA_n   = tea_q;
  assign START_DMA   = start_q;
  assign READ        = read_q;
  assign ADDR        = addr_q;
  assign BYTE_EN     = be_q;
  assign XFER_COUNT  = cnt_q;
  assign TIMEOUT_ERR = err_q;
endmodule

// File: doc/ncr_dma_bridge.md
Name: ncr_dma_bridge

Overview:
Upstream stage of the Zorro III DMA master. Arbitrates the NCR53C710 bus-master request, captures each NCR 68030-style bus cycle, and converts it into one DMA request: a single-cycle start pulse plus read flag, address and byte lanes. It then waits for the master's cycle-done acknowledge and terminates the NCR cycle with TA_n, or with TEA_n if the cycle times out. It also keeps a transfer counter and a sticky timeout flag for the register block.

Parameters:
TIMEOUT_CYCLES, 1024, number of CLK cycles in WAIT_ACK before the cycle is terminated with an error
CNT_W, 16, width of the transfer counter

Ports:
CLK  in  1  system clock
RESET_n  in  1  reset; synchronous, active-low
NCR_BR_n  in  1  NCR bus request
NCR_BG_n  out  1  bus grant to NCR
NCR_BGACK_n  in  1  NCR bus-grant acknowledge (NCR owns bus)
NCR_AS_n  in  1  NCR address strobe
NCR_RW  in  1  1 = NCR read (maps to DMA read from Zorro)
NCR_SIZ  in  2  68030 size: 01 byte, 10 word, 11 three-byte, 00 long
NCR_ADDR  in  32  NCR address
NCR_TA_n  out  1  transfer acknowledge to NCR
NCR_TEA_n  out  1  transfer error to NCR
START_DMA  out  1  one-cycle request to the DMA master
READ  out  1  latched NCR_RW
ADDR  out  32  latched NCR_ADDR, unmodified
BYTE_EN  out  4  active-high lane enables; bit3 = D31:24
DTACK_ACK  in  1  DMA master cycle complete
ACTIVE  in  1  DMA master busy
TIMEOUT_CLR  in  1  clears TIMEOUT_ERR
XFER_COUNT  out  CNT_W  number of completed transfers; wraps
TIMEOUT_ERR  out  1  sticky timeout flag

Behaviour:
- All outputs are registered.
- Reset (any cycle, including mid-transfer): state IDLE; NCR_BG_n, NCR_TA_n, NCR_TEA_n = 1; START_DMA = 0; READ = 0; ADDR = 0; BYTE_EN = 0; XFER_COUNT = 0; TIMEOUT_ERR = 0.
- IDLE: on NCR_BR_n = 0, go to GRANT.
- GRANT: NCR_BG_n = 0.
  - NCR_BGACK_n = 0: go to OWNED.
  - NCR_BR_n = 1 before BGACK arrives: go to IDLE.
- OWNED: NCR_BG_n = 1.
  - NCR_AS_n = 0: latch ADDR, READ and BYTE_EN; go to ISSUE.
  - NCR_BGACK_n = 1 with AS_n negated: go to IDLE (bus released).
- ISSUE: if ACTIVE = 0, pulse START_DMA for exactly one cycle and go to WAIT_ACK. Otherwise hold in ISSUE with START_DMA = 0.
- WAIT_ACK: timeout counter increments each cycle.
  - DTACK_ACK = 1: go to TERM.
  - Counter reaches TIMEOUT_CYCLES-1 without DTACK_ACK: go to ERR.
  - DTACK_ACK on the same cycle as the timeout: DTACK_ACK wins.
- TERM: NCR_TA_n = 0 for one cycle; XFER_COUNT += 1, wrapping from all-ones to 0; go to WAIT_NEG.
- ERR: NCR_TEA_n = 0 for one cycle; TIMEOUT_ERR = 1; XFER_COUNT unchanged; go to WAIT_NEG.
- WAIT_NEG: wait for NCR_AS_n = 1, then go to OWNED.
- Timeout counter clears on entry to WAIT_ACK.
- TIMEOUT_CLR clears TIMEOUT_ERR on the next edge. If TIMEOUT_CLR and an ERR entry occur on the same cycle, the set wins.
- BYTE_EN: let o = NCR_ADDR[1:0] and n = 1/2/3/4 for SIZ 01/10/11/00. Lane k is enabled for o <= k < min(4, o+n); lane k maps to bit (3-k). Examples:
  - long @0: 1111; long @2: 0011
  - word @0: 1100; word @1: 0110; word @2: 0011
  - byte @3: 0001
  - three-byte @1: 0111
- Latency: NCR_AS_n fall to START_DMA = 2 edges when ACTIVE = 0; DTACK_ACK to NCR_TA_n low = 1 edge.

Test Plan:
- Arbitration: BR_n low -> BG_n low next edge; BGACK_n low -> BG_n high. BR_n withdrawn in GRANT -> BG_n high, state IDLE.
- Write long: RW=0, SIZ=00, ADDR=0x4000_0000 -> one START_DMA pulse, READ=0, BYTE_EN=1111. DTACK_ACK -> TA_n low for 1 cycle, XFER_COUNT=1.
- Lane table: read word @0x..01 -> BYTE_EN=0110; byte @0x..03 -> 0001; three-byte @0x..01 -> 0111; long @0x..02 -> 0011.
- ACTIVE held high 5 cycles after AS_n falls -> START_DMA stays 0, then pulses once on the cycle after ACTIVE drops.
- Timeout: TIMEOUT_CYCLES=16, no DTACK_ACK -> TEA_n low 1 cycle, TIMEOUT_ERR=1, XFER_COUNT unchanged. TIMEOUT_CLR -> flag 0. Also DTACK_ACK on cycle 15 -> TA_n, no error.
- Reset in WAIT_ACK -> all outputs at reset values next edge. Count wrap: CNT_W=4, 16 transfers -> XFER_COUNT=0.
